// File: rtl/recirculador_param.sv
// -----------------------------------------------------------------------------
// recirculador_param
//
// Parametrised lane recirculation stage for the PHY data path. Every cycle each
// valid lane word goes either to the main path (toward the FIFOs) or back to
// the recirculation path (toward the stimulus source). Each lane has a one-entry
// hold buffer that absorbs main-path backpressure. A DRAIN state empties the
// holds before the stage recirculates, so a mode change never loses a held
// word. Per-lane sticky flags record words dropped because a hold was full.
//
// Optional feature macro: RECIRC_COUNT_EN
//   defined   : recirc_count is a saturating count of recirculated words.
//   undefined : no counter logic is built and recirc_count is tied to 0.
//
// Ports
//   clk           in   1              clock; all state updates on posedge
//   reset         in   1              asynchronous, active-high reset
//   data_in       in   LANES*DATA_W   lane i = data_in[i*DATA_W +: DATA_W]
//   valid_in      in   LANES          per-lane word valid
//   idl           in   1              1 = link idle/training (recirculate)
//   pause         in   1              main-path backpressure
//   data_out      out  LANES*DATA_W   main-path data, registered
//   valid_out     out  LANES          main-path valid, registered
//   recirc_data   out  LANES*DATA_W   recirculation data, registered
//   recirc_valid  out  LANES          recirculation valid, registered
//   overflow      out  LANES          sticky per-lane drop flag
//   recirc_count  out  CNT_W          saturating recirculated-word count
//
// state   | meaning
// --------+---------------------------------------------------------------
// FWD     | forward to main path; holds absorb pause (reset state)
// DRAIN   | link idle but holds not empty; input recirculates, holds drain
// RECIRC  | link idle, holds empty; all valid input recirculates
// -----------------------------------------------------------------------------
module recirculador_param #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic [LANES-1:0]        valid_in,
    input  logic                    idl,
    input  logic                    pause,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic [LANES*DATA_W-1:0] recirc_data,
    output logic [LANES-1:0]        recirc_valid,
    output logic [LANES-1:0]        overflow,
    output logic [CNT_W-1:0]        recirc_count
);

    typedef enum logic [1:0] {
        ST_FWD    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RECIRC = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LANES*DATA_W-1:0] hold_data;
    logic [LANES-1:0]        hold_full;

    logic [LANES*DATA_W-1:0] nxt_data_out;
    logic [LANES-1:0]        nxt_valid_out;
    logic [LANES*DATA_W-1:0] nxt_recirc_data;
    logic [LANES-1:0]        nxt_recirc_valid;
    logic [LANES*DATA_W-1:0] nxt_hold_data;
    logic [LANES-1:0]        nxt_hold_full;
    logic [LANES-1:0]        nxt_overflow;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FWD;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Hold occupancy is judged after this edge's
    // updates, so a word captured on the same edge idl rises still forces
    // a pass through DRAIN instead of being stranded in RECIRC.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FWD: begin
                if (idl) begin
                    state_nxt = (|nxt_hold_full) ? ST_DRAIN : ST_RECIRC;
                end
            end
            ST_DRAIN: begin
                if (!idl) begin
                    state_nxt = ST_FWD;
                end else if (!(|nxt_hold_full)) begin
                    state_nxt = ST_RECIRC;
                end
            end
            ST_RECIRC: begin
                if (!idl) begin
                    state_nxt = ST_FWD;
                end
            end
            default: state_nxt = ST_FWD;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / lane routing logic. Data registers keep their previous
    // contents unless a word is actually emitted on that path.
    // ------------------------------------------------------------------
    always_comb begin
        nxt_data_out     = data_out;
        nxt_valid_out    = '0;
        nxt_recirc_data  = recirc_data;
        nxt_recirc_valid = '0;
        nxt_hold_data    = hold_data;
        nxt_hold_full    = hold_full;
        nxt_overflow     = overflow;

        for (int i = 0; i < LANES; i++) begin
            case (state)
                ST_FWD: begin
                    if (hold_full[i]) begin
                        if (!pause) begin
                            nxt_data_out[i*DATA_W +: DATA_W] = hold_data[i*DATA_W +: DATA_W];
                            nxt_valid_out[i] = 1'b1;
                            nxt_hold_full[i] = valid_in[i];
                            if (valid_in[i]) begin
                                nxt_hold_data[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                            end
                        end else if (valid_in[i]) begin
                            // hold occupied and main path stalled: word is lost
                            nxt_overflow[i] = 1'b1;
                        end
                    end else if (valid_in[i]) begin
                        if (!pause) begin
                            nxt_data_out[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                            nxt_valid_out[i] = 1'b1;
                        end else begin
                            nxt_hold_data[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                            nxt_hold_full[i] = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_in[i]) begin
                        nxt_recirc_data[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                        nxt_recirc_valid[i] = 1'b1;
                    end
                    if (hold_full[i] && !pause) begin
                        nxt_data_out[i*DATA_W +: DATA_W] = hold_data[i*DATA_W +: DATA_W];
                        nxt_valid_out[i] = 1'b1;
                        nxt_hold_full[i] = 1'b0;
                    end
                end
                default: begin
                    // RECIRC: holds are always empty here; pause is irrelevant
                    if (valid_in[i]) begin
                        nxt_recirc_data[i*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                        nxt_recirc_valid[i] = 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out     <= '0;
            valid_out    <= '0;
            recirc_data  <= '0;
            recirc_valid <= '0;
            overflow     <= '0;
            hold_data    <= '0;
            hold_full    <= '0;
        end else begin
            data_out     <= nxt_data_out;
            valid_out    <= nxt_valid_out;
            recirc_data  <= nxt_recirc_data;
            recirc_valid <= nxt_recirc_valid;
            overflow     <= nxt_overflow;
            hold_data    <= nxt_hold_data;
            hold_full    <= nxt_hold_full;
        end
    end

    // ------------------------------------------------------------------
    // Recirculated-word counter
    // ------------------------------------------------------------------
`ifdef RECIRC_COUNT_EN
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + PC_W;

    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [SUM_W-1:0] cnt_max;

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PC_W'(nxt_recirc_valid[i]);
        end
    end

    // widened add so the saturation compare sees the carry
    assign cnt_sum = SUM_W'(recirc_count) + SUM_W'(pop);
    assign cnt_max = SUM_W'({CNT_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recirc_count <= '0;
        end else if (cnt_sum > cnt_max) begin
            recirc_count <= {CNT_W{1'b1}};
        end else begin
            recirc_count <= cnt_sum[CNT_W-1:0];
        end
    end
`else
    assign recirc_count = '0;
`endif

endmodule

// File: tb/tb_recirculador_param.sv
module tb_recirculador_param;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 4;

`ifdef RECIRC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] S_FWD    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_RECIRC = 2'd2;

    logic                    clk;
    logic                    reset;
    logic [LANES*DATA_W-1:0] data_in;
    logic [LANES-1:0]        valid_in;
    logic                    idl;
    logic                    pause;
    logic [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0]        valid_out;
    logic [LANES*DATA_W-1:0] recirc_data;
    logic [LANES-1:0]        recirc_valid;
    logic [LANES-1:0]        overflow;
    logic [CNT_W-1:0]        recirc_count;

    int n_chk = 0;
    int n_bad = 0;

    recirculador_param #(
        .DATA_W(DATA_W),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .idl         (idl),
        .pause       (pause),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .recirc_data (recirc_data),
        .recirc_valid(recirc_valid),
        .overflow    (overflow),
        .recirc_count(recirc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic [31:0] d, input logic [3:0] v, input logic i, input logic p);
        data_in  = d;
        valid_in = v;
        idl      = i;
        pause    = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        drv(32'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [CNT_W-1:0] sat_tbl [4];

    initial begin
        sat_tbl[0] = 4'd4;
        sat_tbl[1] = 4'd8;
        sat_tbl[2] = 4'd12;
        sat_tbl[3] = 4'd15;

        // ---- reset state
        reset = 1'b1;
        drv(32'h0, 4'h0, 1'b0, 1'b0);
        #7;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid_out", valid_out, 4'h0);
        chk("rst_recirc_valid", recirc_valid, 4'h0);
        chk("rst_overflow", overflow, 4'h0);
        chk("rst_count", recirc_count, 4'd0);
        chk("rst_state", dut.state, S_FWD);
        @(negedge clk);
        reset = 1'b0;

        // ---- forward, all lanes
        drv(32'h44332211, 4'hF, 1'b0, 1'b0);
        tick();
        chk("fwd_data_out", data_out, 32'h44332211);
        chk("fwd_valid_out", valid_out, 4'hF);
        chk("fwd_recirc_valid", recirc_valid, 4'h0);

        // ---- idl held: first word forwarded, second recirculated
        drv(32'h88776655, 4'hF, 1'b1, 1'b0);
        tick();
        chk("idl_first_data_out", data_out, 32'h88776655);
        chk("idl_first_valid_out", valid_out, 4'hF);
        chk("idl_first_recirc_valid", recirc_valid, 4'h0);
        chk("idl_first_state", dut.state, S_RECIRC);
        drv(32'hCCBBAA99, 4'hF, 1'b1, 1'b0);
        tick();
        chk("rc_recirc_data", recirc_data, 32'hCCBBAA99);
        chk("rc_recirc_valid", recirc_valid, 4'hF);
        chk("rc_valid_out", valid_out, 4'h0);
        chk("rc_data_out_held", data_out, 32'h88776655);
        chk("rc_count", recirc_count, CNT_EN ? 4'd4 : 4'd0);
        drv(32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("rc_idle_recirc_valid", recirc_valid, 4'h0);
        chk("rc_idle_recirc_data_held", recirc_data, 32'hCCBBAA99);
        chk("rc_idle_count", recirc_count, CNT_EN ? 4'd4 : 4'd0);

        // ---- reset asserted mid-stream
        drv(32'h04030201, 4'hF, 1'b1, 1'b0);
        tick();
        chk("pre_rst_count", recirc_count, CNT_EN ? 4'd8 : 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_data_out", data_out, 32'h0);
        chk("mid_rst_recirc_data", recirc_data, 32'h0);
        chk("mid_rst_recirc_valid", recirc_valid, 4'h0);
        chk("mid_rst_count", recirc_count, 4'd0);
        drv(32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_state", dut.state, S_FWD);
        drv(32'h0D0C0B0A, 4'hF, 1'b0, 1'b0);
        tick();
        chk("post_rst_fwd_data", data_out, 32'h0D0C0B0A);
        chk("post_rst_fwd_valid", valid_out, 4'hF);
        chk("post_rst_count", recirc_count, 4'd0);

        // ---- backpressure, hold and overflow on lane 0
        drv(32'h000000AA, 4'h1, 1'b0, 1'b1);
        tick();
        chk("bp_capture_valid_out", valid_out, 4'h0);
        chk("bp_capture_overflow", overflow, 4'h0);
        drv(32'h000000BB, 4'h1, 1'b0, 1'b1);
        tick();
        chk("bp_drop_valid_out", valid_out, 4'h0);
        chk("bp_drop_overflow", overflow, 4'h1);
        drv(32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        chk("bp_release_data_out", data_out, 32'h0D0C0BAA);
        chk("bp_release_valid_out", valid_out, 4'h1);
        tick();
        chk("bp_dropped_gone", valid_out, 4'h0);
        drv(32'h00000011, 4'h1, 1'b0, 1'b1);
        tick();
        drv(32'h00000022, 4'h1, 1'b0, 1'b0);
        tick();
        chk("refill_emit_data", data_out, 32'h0D0C0B11);
        chk("refill_emit_valid", valid_out, 4'h1);
        drv(32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        chk("refill_second_data", data_out, 32'h0D0C0B22);
        chk("refill_second_valid", valid_out, 4'h1);
        chk("overflow_sticky", overflow, 4'h1);

        // ---- drain: held word survives the mode change
        rst_pulse();
        drv(32'h000000AA, 4'h1, 1'b0, 1'b1);
        tick();
        chk("dr_capture_valid_out", valid_out, 4'h0);
        drv(32'h0, 4'h0, 1'b1, 1'b1);
        tick();
        chk("dr_enter_state", dut.state, S_DRAIN);
        chk("dr_enter_valid_out", valid_out, 4'h0);
        drv(32'h000000DD, 4'h1, 1'b1, 1'b1);
        tick();
        chk("dr_recirc_data", recirc_data, 32'h000000DD);
        chk("dr_recirc_valid", recirc_valid, 4'h1);
        chk("dr_valid_out_paused", valid_out, 4'h0);
        chk("dr_no_overflow", overflow, 4'h0);
        chk("dr_stay_state", dut.state, S_DRAIN);
        drv(32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("dr_emit_data", data_out, 32'h000000AA);
        chk("dr_emit_valid", valid_out, 4'h1);
        chk("dr_emit_recirc_valid", recirc_valid, 4'h0);
        chk("dr_exit_state", dut.state, S_RECIRC);
        chk("dr_count", recirc_count, CNT_EN ? 4'd1 : 4'd0);

        // ---- counter saturation (CNT_W = 4)
        rst_pulse();
        drv(32'h0, 4'h0, 1'b1, 1'b0);
        tick();
        chk("sat_state", dut.state, S_RECIRC);
        for (int k = 0; k < 4; k++) begin
            drv(32'hF0E0D0C0 + 32'(k), 4'hF, 1'b1, 1'b0);
            tick();
            chk($sformatf("sat_count_%0d", k), recirc_count, CNT_EN ? sat_tbl[k] : 4'd0);
        end
        drv(32'h5A5A5A5A, 4'hF, 1'b1, 1'b1);
        tick();
        chk("sat_no_wrap", recirc_count, CNT_EN ? 4'd15 : 4'd0);
        chk("sat_pause_ignored", recirc_valid, 4'hF);
        chk("sat_pause_valid_out", valid_out, 4'h0);
        chk("sat_pause_data", recirc_data, 32'h5A5A5A5A);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
